// File: rtl/priority_encoder_8to3.sv
// Registered priority encoder: picks the highest-set request bit of u and
// reports its index, a one-hot grant, a valid flag and a multiple-request flag.

// One request position in the priority chain. above_any is set when any
// higher-priority request is active.
module priority_encoder_8to3_lane (
   input  logic req,
   input  logic above_any,
   output logic gnt,
   output logic dup,
   output logic below_any
);
   assign gnt       = req & ~above_any;
   assign dup       = req & above_any;
   assign below_any = req | above_any;
endmodule

module priority_encoder_8to3 #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] u,
   output logic [IDX_W-1:0] i,
   output logic             valid,
   output logic [WIDTH-1:0] grant,
   output logic             multi
);
   // AND-gating keeps an unknown u from reaching the flops while en=0.
   logic [WIDTH-1:0] u_g;
   logic [WIDTH:0]   above;
   logic [WIDTH-1:0] gnt_c;
   logic [WIDTH-1:0] dup_c;
   logic [IDX_W-1:0] idx_c;

   assign u_g          = u & {WIDTH{en}};
   assign above[WIDTH] = 1'b0;

   // Chain runs from the MSB down: each lane sees whether anything above it won.
   genvar k;
   generate
      for (k = WIDTH - 1; k >= 0; k--) begin : g_lane
         priority_encoder_8to3_lane u_lane (
            .req       (u_g[k]),
            .above_any (above[k+1]),
            .gnt       (gnt_c[k]),
            .dup       (dup_c[k]),
            .below_any (above[k])
         );
      end
   endgenerate

   always_comb begin
      idx_c = '0;
      for (int b = 0; b < WIDTH; b++) begin
         if (gnt_c[b]) idx_c = idx_c | IDX_W'(b);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         i     <= '0;
         valid <= 1'b0;
         grant <= '0;
         multi <= 1'b0;
      end else begin
         i     <= idx_c;
         valid <= above[0];
         grant <= gnt_c;
         multi <= |dup_c;
      end
   end
endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed self-checking bench for priority_encoder_8to3; observed outputs are
// packed as {i, valid, grant, multi} and compared against hand-computed values.
module tb_priority_encoder_8to3;
   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] u;
   logic [2:0] i;
   logic       valid;
   logic [7:0] grant;
   logic       multi;

   int checks = 0;
   int errors = 0;

   priority_encoder_8to3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .u     (u),
      .i     (i),
      .valid (valid),
      .grant (grant),
      .multi (multi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] obs();
      return {i, valid, grant, multi};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; u = 8'hFF;
      tick();
      checks++;
      if (obs() !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
         errors++; $display("FAIL reset_edge1 got %h exp %h", obs(), {3'd0, 1'b0, 8'h00, 1'b0});
      end
      tick();
      checks++;
      if (obs() !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
         errors++; $display("FAIL reset_edge2 got %h exp %h", obs(), {3'd0, 1'b0, 8'h00, 1'b0});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs() !== {3'd7, 1'b1, 8'h80, 1'b1}) begin
         errors++; $display("FAIL reset_release got %h exp %h", obs(), {3'd7, 1'b1, 8'h80, 1'b1});
      end
   endtask

   task automatic test_onehot_sweep();
      logic [7:0] vec [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
      logic [2:0] idx [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      en = 1'b1;
      for (int n = 0; n < 8; n++) begin
         u = vec[n];
         tick();
         checks++;
         if (obs() !== {idx[n], 1'b1, vec[n], 1'b0}) begin
            errors++;
            $display("FAIL onehot[%0d] got %h exp %h", n, obs(), {idx[n], 1'b1, vec[n], 1'b0});
         end
      end
   endtask

   task automatic test_priority();
      en = 1'b1; u = 8'b0010_1101;
      tick();
      checks++;
      if (obs() !== {3'd5, 1'b1, 8'h20, 1'b1}) begin
         errors++; $display("FAIL prio_2d got %h exp %h", obs(), {3'd5, 1'b1, 8'h20, 1'b1});
      end
      u = 8'b0000_0011;
      tick();
      checks++;
      if (obs() !== {3'd1, 1'b1, 8'h02, 1'b1}) begin
         errors++; $display("FAIL prio_03 got %h exp %h", obs(), {3'd1, 1'b1, 8'h02, 1'b1});
      end
      u = 8'b1000_0001;
      tick();
      checks++;
      if (obs() !== {3'd7, 1'b1, 8'h80, 1'b1}) begin
         errors++; $display("FAIL prio_81 got %h exp %h", obs(), {3'd7, 1'b1, 8'h80, 1'b1});
      end
   endtask

   task automatic test_disable_x();
      en = 1'b1; u = 8'h24;
      tick();
      en = 1'b0; u = 8'bx;
      tick();
      checks++;
      if (obs() !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
         errors++; $display("FAIL disable_x got %h exp %h", obs(), {3'd0, 1'b0, 8'h00, 1'b0});
      end
      en = 1'b0; u = 8'hFF;
      tick();
      checks++;
      if (obs() !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
         errors++; $display("FAIL disable_ff got %h exp %h", obs(), {3'd0, 1'b0, 8'h00, 1'b0});
      end
   endtask

   task automatic test_zero();
      en = 1'b1; u = 8'h00;
      tick();
      checks++;
      if (obs() !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
         errors++; $display("FAIL zero got %h exp %h", obs(), {3'd0, 1'b0, 8'h00, 1'b0});
      end
      u = 8'h01;
      tick();
      checks++;
      if (obs() !== {3'd0, 1'b1, 8'h01, 1'b0}) begin
         errors++; $display("FAIL one got %h exp %h", obs(), {3'd0, 1'b1, 8'h01, 1'b0});
      end
   endtask

   task automatic test_mid_reset();
      en = 1'b1; u = 8'h40;
      tick();
      checks++;
      if (obs() !== {3'd6, 1'b1, 8'h40, 1'b0}) begin
         errors++; $display("FAIL mid_pre got %h exp %h", obs(), {3'd6, 1'b1, 8'h40, 1'b0});
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (obs() !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
         errors++; $display("FAIL mid_rst got %h exp %h", obs(), {3'd0, 1'b0, 8'h00, 1'b0});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs() !== {3'd6, 1'b1, 8'h40, 1'b0}) begin
         errors++; $display("FAIL mid_post got %h exp %h", obs(), {3'd6, 1'b1, 8'h40, 1'b0});
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; u = 8'h00;
      test_reset();
      test_onehot_sweep();
      test_priority();
      test_disable_x();
      test_zero();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
